// File: rtl/pio_out_blink.sv
// pio_out_blink: Avalon-MM parallel output port with DATA/SET/CLR access
// and an optional blink engine that periodically inverts masked bits.
// Optional feature macro: PIO_OUT_BLINK_EN builds the BLINK_MASK/PERIOD
// registers, the period counter and the phase flip-flop. Without it,
// addresses 3 and 4 are reserved and out_port is the plain data register.
module pio_out_blink #(
    parameter int WIDTH        = 8,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_MASK   = 3'd3;
    localparam logic [2:0] ADDR_PERIOD = 3'd4;

    logic             wr;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] wr_bits;

    // Only bits that fit the output register can ever be stored, and the
    // parameter is referenced even when no counter exists.
    logic unused_ok;
    assign unused_ok = ^writedata ^ (PERIOD_WIDTH != 0);

    assign wr      = chipselect & ~write_n;
    assign wr_bits = writedata[WIDTH-1:0];

    // Data register: direct load, bitwise set and bitwise clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
        end else if (wr) begin
            case (address)
                ADDR_DATA: data_out <= wr_bits;
                ADDR_SET:  data_out <= data_out | wr_bits;
                ADDR_CLR:  data_out <= data_out & ~wr_bits;
                default:   data_out <= data_out;
            endcase
        end
    end

`ifdef PIO_OUT_BLINK_EN
    logic [WIDTH-1:0]        blink_mask;
    logic [PERIOD_WIDTH-1:0] period;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic                    phase;

    // Blink mask register; writing it leaves the counter and phase alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_mask <= '0;
        end else if (wr && address == ADDR_MASK) begin
            blink_mask <= wr_bits;
        end
    end

    // Period register plus counter/phase: a period write restarts the cycle,
    // a zero period parks everything, otherwise phase flips every PERIOD+1 clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period <= '0;
            cnt    <= '0;
            phase  <= 1'b0;
        end else if (wr && address == ADDR_PERIOD) begin
            period <= writedata[PERIOD_WIDTH-1:0];
            cnt    <= '0;
            phase  <= 1'b0;
        end else if (period == '0) begin
            cnt    <= '0;
            phase  <= 1'b0;
        end else if (cnt == period) begin
            cnt    <= '0;
            phase  <= ~phase;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end

    assign out_port = data_out ^ (blink_mask & {WIDTH{phase}});
`else
    assign out_port = data_out;
`endif

    // Combinational, side-effect-free read mux with zero extension.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0] = data_out;
            ADDR_SET:    readdata[WIDTH-1:0] = out_port;
`ifdef PIO_OUT_BLINK_EN
            ADDR_MASK:   readdata[WIDTH-1:0] = blink_mask;
            ADDR_PERIOD: readdata[PERIOD_WIDTH-1:0] = period;
`endif
            default:     readdata = '0;
        endcase
    end

endmodule
